// File: rtl/eth_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkt_arbiter
// Brief    : Round-robin packet arbiter from two ingress FIFOs to egress A/B,
//            routing on the sop-word destination and dropping unknown ones.
// Revision : 1.0
// ============================================================================
module eth_pkt_arbiter #(
    parameter logic [31:0] PORT_A_ADDR = 32'hABCD,
    parameter logic [31:0] PORT_B_ADDR = 32'hEFEF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty_a,
    input  logic             fifo_empty_b,
    input  logic [65:0]      fifo_dout_a,
    input  logic [65:0]      fifo_dout_b,
    output logic             fifo_rd_en_a,
    output logic             fifo_rd_en_b,
    input  logic             tx_ready_a,
    input  logic             tx_ready_b,
    output logic [31:0]      outdataA,
    output logic [31:0]      outdataB,
    output logic             outsopA,
    output logic             outsopB,
    output logic             outeopA,
    output logic             outeopB,
    output logic             outvalidA,
    output logic             outvalidB,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CAP_SOP  = 3'd1;
    localparam logic [2:0] c_OUT      = 3'd2;
    localparam logic [2:0] c_RD       = 3'd3;
    localparam logic [2:0] c_CAP      = 3'd4;
    localparam logic [2:0] c_DROP_RD  = 3'd5;
    localparam logic [2:0] c_DROP_CAP = 3'd6;

    logic [2:0]       r_state;
    logic             r_src;
    logic             r_dest;
    logic             r_rrPtr;
    logic [31:0]      r_outData;
    logic             r_outSop;
    logic             r_outEop;
    logic             r_outValid;
    logic [CNT_W-1:0] r_dropCnt;
    logic [CNT_W-1:0] r_errCnt;

    logic [65:0]      w_dout;
    logic             w_empty;
    logic             w_any;
    logic             w_sel;
    logic             w_txReady;
    logic             w_handshake;
    logic             w_destA;
    logic             w_destB;
    logic             w_rdReq;
    logic             w_rdSrc;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_dout      = r_src ? fifo_dout_b : fifo_dout_a;
    assign w_empty     = r_src ? fifo_empty_b : fifo_empty_a;
    assign w_any       = !fifo_empty_a || !fifo_empty_b;
    // Both pending: honour rr_ptr; otherwise take whichever one has data.
    assign w_sel       = (!fifo_empty_a && !fifo_empty_b) ? r_rrPtr : fifo_empty_a;
    assign w_txReady   = r_dest ? tx_ready_b : tx_ready_a;
    assign w_handshake = (r_state == c_OUT) && w_txReady;
    assign w_destA     = (w_dout[32:1] == PORT_A_ADDR);
    assign w_destB     = (w_dout[32:1] == PORT_B_ADDR);

    always_comb begin
        w_rdReq = 1'b0;
        w_rdSrc = r_src;
        case (r_state)
            c_IDLE: begin
                w_rdReq = w_any;
                w_rdSrc = w_sel;
            end
            c_OUT:     w_rdReq = w_handshake && !r_outEop && !w_empty;
            c_RD:      w_rdReq = !w_empty;
            c_DROP_RD: w_rdReq = !w_empty;
            default:   w_rdReq = 1'b0;
        endcase
    end

    assign fifo_rd_en_a = rstn && w_rdReq && !w_rdSrc;
    assign fifo_rd_en_b = rstn && w_rdReq &&  w_rdSrc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_IDLE;
            r_src      <= 1'b0;
            r_dest     <= 1'b0;
            r_rrPtr    <= 1'b0;
            r_outData  <= '0;
            r_outSop   <= 1'b0;
            r_outEop   <= 1'b0;
            r_outValid <= 1'b0;
            r_dropCnt  <= '0;
            r_errCnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_src   <= w_sel;
                        r_state <= c_CAP_SOP;
                    end
                end
                c_CAP_SOP: begin
                    if (!w_dout[0] || !(w_destA || w_destB)) begin
                        if (!w_dout[0]) r_errCnt  <= satInc(r_errCnt);
                        else            r_dropCnt <= satInc(r_dropCnt);
                        // A single-word head that is discarded ends the packet here.
                        if (w_dout[65]) begin
                            r_rrPtr <= ~r_src;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_DROP_RD;
                        end
                    end else begin
                        r_dest     <= !w_destA;
                        r_outData  <= w_dout[64:33];
                        r_outSop   <= 1'b1;
                        r_outEop   <= w_dout[65];
                        r_outValid <= 1'b1;
                        r_state    <= c_OUT;
                    end
                end
                c_OUT: begin
                    if (w_handshake) begin
                        r_outValid <= 1'b0;
                        if (r_outEop) begin
                            r_rrPtr <= ~r_src;
                            r_state <= c_IDLE;
                        end else if (!w_empty) begin
                            r_state <= c_CAP;
                        end else begin
                            r_state <= c_RD;
                        end
                    end
                end
                c_RD: begin
                    if (!w_empty) r_state <= c_CAP;
                end
                c_CAP: begin
                    if (w_dout[0]) r_errCnt <= satInc(r_errCnt);
                    r_outData  <= w_dout[64:33];
                    r_outSop   <= 1'b0;
                    r_outEop   <= w_dout[65];
                    r_outValid <= 1'b1;
                    r_state    <= c_OUT;
                end
                c_DROP_RD: begin
                    if (!w_empty) r_state <= c_DROP_CAP;
                end
                c_DROP_CAP: begin
                    if (w_dout[65]) begin
                        r_rrPtr <= ~r_src;
                        r_state <= c_IDLE;
                    end else begin
                        r_state <= c_DROP_RD;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign outdataA  = r_dest ? '0   : r_outData;
    assign outdataB  = r_dest ? r_outData : '0;
    assign outsopA   = r_outSop   && !r_dest;
    assign outsopB   = r_outSop   &&  r_dest;
    assign outeopA   = r_outEop   && !r_dest;
    assign outeopB   = r_outEop   &&  r_dest;
    assign outvalidA = r_outValid && !r_dest;
    assign outvalidB = r_outValid &&  r_dest;
    assign drop_cnt  = r_dropCnt;
    assign err_cnt   = r_errCnt;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_pkt_arbiter
// Brief    : Scoreboard bench for eth_pkt_arbiter with a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_eth_pkt_arbiter;
    localparam int          TB_CNT_W = 3;
    localparam int          MAXC     = (1 << TB_CNT_W) - 1;
    localparam logic [31:0] ADDR_A   = 32'hABCD;
    localparam logic [31:0] ADDR_B   = 32'hEFEF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic fifo_empty_a = 1'b1, fifo_empty_b = 1'b1;
    logic [65:0] fifo_dout_a = '0, fifo_dout_b = '0;
    logic fifo_rd_en_a, fifo_rd_en_b;
    logic tx_ready_a = 1'b0, tx_ready_b = 1'b0;
    logic [31:0] outdataA, outdataB;
    logic outsopA, outsopB, outeopA, outeopB, outvalidA, outvalidB;
    logic [TB_CNT_W-1:0] drop_cnt, err_cnt;
    logic busy;

    eth_pkt_arbiter #(.PORT_A_ADDR(ADDR_A), .PORT_B_ADDR(ADDR_B), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .fifo_empty_a(fifo_empty_a), .fifo_empty_b(fifo_empty_b),
        .fifo_dout_a(fifo_dout_a), .fifo_dout_b(fifo_dout_b),
        .fifo_rd_en_a(fifo_rd_en_a), .fifo_rd_en_b(fifo_rd_en_b),
        .tx_ready_a(tx_ready_a), .tx_ready_b(tx_ready_b),
        .outdataA(outdataA), .outdataB(outdataB),
        .outsopA(outsopA), .outsopB(outsopB),
        .outeopA(outeopA), .outeopB(outeopB),
        .outvalidA(outvalidA), .outvalidB(outvalidB),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO contents seen by the DUT, pending trickle words, and model copies
    logic [65:0] qa[$], qb[$], pa[$], pb[$], mA[$], mB[$];
    // Expected egress words: {port(1=B), eop, sop, data}
    logic [34:0] expQ[$];
    int nCmp = 0, nFail = 0;
    int readyMode = 1;
    int pops = 0;
    int mDrop = 0, mErr = 0;
    logic mRr = 1'b0;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        logic ra, rb;
        @(negedge clk);
        ra = fifo_rd_en_a;
        rb = fifo_rd_en_b;
        @(posedge clk);
        #1;
        if (ra) begin
            if (qa.size() == 0) begin nFail++; $display("FAIL rd_empty_a: read of empty FIFO A"); end
            else begin fifo_dout_a = qa.pop_front(); pops++; end
        end
        if (rb) begin
            if (qb.size() == 0) begin nFail++; $display("FAIL rd_empty_b: read of empty FIFO B"); end
            else begin fifo_dout_b = qb.pop_front(); pops++; end
        end
        if (pa.size() > 0 && $urandom_range(0, 2) == 0) qa.push_back(pa.pop_front());
        if (pb.size() > 0 && $urandom_range(0, 2) == 0) qb.push_back(pb.pop_front());
        fifo_empty_a = (qa.size() == 0);
        fifo_empty_b = (qb.size() == 0);
        if (readyMode == 0) begin
            tx_ready_a = ($urandom_range(0, 3) != 0);
            tx_ready_b = ($urandom_range(0, 3) != 0);
        end else if (readyMode == 1) begin
            tx_ready_a = 1'b1;
            tx_ready_b = 1'b1;
        end
    endtask

    // tgt: 0/1 straight into FIFO A/B, 2/3 trickled into FIFO A/B
    task automatic push_word(input int tgt, input logic [65:0] w);
        case (tgt)
            0: begin qa.push_back(w); mA.push_back(w); end
            1: begin qb.push_back(w); mB.push_back(w); end
            2: begin pa.push_back(w); mA.push_back(w); end
            default: begin pb.push_back(w); mB.push_back(w); end
        endcase
        fifo_empty_a = (qa.size() == 0);
        fifo_empty_b = (qb.size() == 0);
    endtask

    task automatic mk(input int tgt, input logic eop, input logic [31:0] data,
                      input logic [31:0] dest, input logic sop);
        push_word(tgt, {eop, data, dest, sop});
    endtask

    task automatic gen_pkt(input int tgt);
        int len, kind;
        logic [31:0] dest;
        logic sop;
        len  = $urandom_range(1, 5);
        kind = $urandom_range(0, 9);
        if (kind <= 1) begin
            dest = $urandom;
            while (dest == ADDR_A || dest == ADDR_B) dest = $urandom;
        end else begin
            dest = ($urandom_range(0, 1) == 1) ? ADDR_B : ADDR_A;
        end
        for (int i = 0; i < len; i++) begin
            sop = (i == 0) ? (kind != 2) : ($urandom_range(0, 7) == 0);
            mk(tgt, (i == len - 1), $urandom, dest, sop);
        end
    endtask

    // Packet-level reference: round-robin over whole packets, classify each one.
    task automatic model_run();
        logic [65:0] pkt[$];
        logic [65:0] w;
        logic s, port;
        while (mA.size() > 0 || mB.size() > 0) begin
            if (mA.size() > 0 && mB.size() > 0) s = mRr;
            else s = (mA.size() > 0) ? 1'b0 : 1'b1;
            pkt.delete();
            do begin
                w = s ? mB.pop_front() : mA.pop_front();
                pkt.push_back(w);
            end while (!w[65] && ((s ? mB.size() : mA.size()) > 0));
            w = pkt[0];
            if (!w[0]) begin
                mErr = sat(mErr);
            end else if (w[32:1] == ADDR_A || w[32:1] == ADDR_B) begin
                port = (w[32:1] != ADDR_A);
                for (int i = 0; i < pkt.size(); i++) begin
                    w = pkt[i];
                    expQ.push_back({port, w[65], (i == 0), w[64:33]});
                    if (i > 0 && w[0]) mErr = sat(mErr);
                end
            end else begin
                mDrop = sat(mDrop);
            end
            mRr = ~s;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(qa.size() == 0 && qb.size() == 0 && pa.size() == 0 && pb.size() == 0 &&
                 expQ.size() == 0 && !busy) && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) begin
            nFail++;
            $display("FAIL drain_timeout: %0d words still expected, busy=%0b", expQ.size(), busy);
            expQ.delete();
            pa.delete();
            pb.delete();
        end
        tick();
        tick();
        chk("drop_cnt", drop_cnt, mDrop);
        chk("err_cnt", err_cnt, mErr);
        chk("busy_idle", busy, 0);
    endtask

    // Monitor: pops the scoreboard on every egress handshake and watches invariants.
    logic [34:0] prevOut = '0;
    logic prevStall = 1'b0;
    always @(negedge clk) begin
        logic [34:0] got, e;
        logic hs;
        if (!rstn) begin
            prevStall = 1'b0;
        end else begin
            if (outvalidA && outvalidB) begin nFail++; $display("FAIL both_valid: outvalidA=1 outvalidB=1 required one-hot"); end
            if (fifo_rd_en_a && fifo_rd_en_b) begin nFail++; $display("FAIL both_rd_en: both read enables high"); end
            got = outvalidB ? {1'b1, outeopB, outsopB, outdataB} : {1'b0, outeopA, outsopA, outdataA};
            hs  = (outvalidA && tx_ready_a) || (outvalidB && tx_ready_b);
            if (prevStall) begin
                nCmp++;
                if (!(outvalidA || outvalidB) || got !== prevOut) begin
                    nFail++;
                    $display("FAIL stall_hold: got %0h valid=%0b required %0h held", got, outvalidA || outvalidB, prevOut);
                end
            end
            if ((outvalidA || outvalidB) && !hs && (fifo_rd_en_a || fifo_rd_en_b)) begin
                nFail++;
                $display("FAIL stall_rd_en: rd_en=1 while output stalled, required 0");
            end
            if (hs) begin
                nCmp++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL egress_word: got unexpected %0h, required no output", got);
                end else begin
                    e = expQ.pop_front();
                    if (got !== e) begin
                        nFail++;
                        $display("FAIL egress_word: got %0h required %0h", got, e);
                    end
                end
            end
            prevStall = (outvalidA || outvalidB) && !hs;
            prevOut   = got;
        end
    end

    initial begin
        logic [31:0] held;
        logic found;
        readyMode = 1;
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_validA", outvalidA, 0);
        chk("rst_validB", outvalidB, 0);
        chk("rst_dataA", outdataA, 0);
        chk("rst_rd_en", {fifo_rd_en_a, fifo_rd_en_b}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnts", {drop_cnt, err_cnt}, 0);
        rstn = 1'b1;
        tick();

        // Both FIFOs hold 2-word packets to A: A's packet first, then B's
        mk(0, 1'b0, 32'h10, ADDR_A, 1'b1); mk(0, 1'b1, 32'h11, ADDR_A, 1'b0);
        mk(1, 1'b0, 32'h20, ADDR_A, 1'b1); mk(1, 1'b1, 32'h21, ADDR_A, 1'b0);
        model_run();
        drain();

        // 3-word packet from FIFO A to egress B: 2-cycle latency, 2 cycles/word
        mk(0, 1'b0, 32'd1, ADDR_B, 1'b1);
        mk(0, 1'b0, 32'd2, ADDR_B, 1'b0);
        mk(0, 1'b1, 32'd3, ADDR_B, 1'b0);
        model_run();
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("timing_validB", outvalidB, (k % 2 == 0));
            chk("timing_validA", outvalidA, 0);
            if (k % 2 == 0) chk("timing_dataB", outdataB, k / 2);
        end
        chk("after_busy", busy, 0);
        drain();

        // Backpressure on egress A mid-packet
        readyMode = 2;
        tx_ready_a = 1'b1;
        tx_ready_b = 1'b1;
        mk(0, 1'b0, 32'h31, ADDR_A, 1'b1);
        mk(0, 1'b0, 32'h32, ADDR_A, 1'b0);
        mk(0, 1'b1, 32'h33, ADDR_A, 1'b0);
        model_run();
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            tick();
            if (outvalidA && !outsopA) found = 1'b1;
        end
        chk("bp_reached", found, 1);
        tx_ready_a = 1'b0;
        held = outdataA;
        pops = 0;
        repeat (5) tick();
        chk("bp_no_rd", pops, 0);
        chk("bp_valid", outvalidA, 1);
        chk("bp_data", outdataA, held);
        readyMode = 1;
        drain();

        // Unknown destination: 4 reads, no output, drop_cnt=1; then a normal packet
        pops = 0;
        mk(0, 1'b0, 32'h1, 32'h1234, 1'b1);
        mk(0, 1'b0, 32'h2, 32'h1234, 1'b0);
        mk(0, 1'b0, 32'h3, 32'h1234, 1'b0);
        mk(0, 1'b1, 32'h4, 32'h1234, 1'b0);
        model_run();
        drain();
        chk("drop_reads", pops, 4);
        chk("drop_one", drop_cnt, 1);
        mk(0, 1'b0, 32'h41, ADDR_B, 1'b1);
        mk(0, 1'b1, 32'h42, ADDR_B, 1'b0);
        model_run();
        drain();

        // Orphan head word, then a packet carrying a stray mid-packet sop
        mk(0, 1'b0, 32'h51, ADDR_A, 1'b0);
        mk(0, 1'b1, 32'h52, ADDR_A, 1'b0);
        mk(0, 1'b0, 32'h61, ADDR_B, 1'b1);
        mk(0, 1'b0, 32'h62, ADDR_B, 1'b1);
        mk(0, 1'b1, 32'h63, ADDR_B, 1'b0);
        model_run();
        drain();
        chk("err_two", err_cnt, 2);

        // Random batches into both FIFOs with random egress readiness
        readyMode = 0;
        for (int b = 0; b < 25; b++) begin
            for (int p = $urandom_range(0, 3); p > 0; p--) gen_pkt(0);
            for (int p = $urandom_range(0, 3); p > 0; p--) gen_pkt(1);
            model_run();
            drain();
        end

        // Trickled words into one FIFO, exercising the mid-packet empty wait
        for (int b = 0; b < 10; b++) begin
            for (int p = 0; p < 2; p++) gen_pkt(2 + (b % 2));
            model_run();
            drain();
        end

        // Reset while a packet is being output
        readyMode = 2;
        tx_ready_a = 1'b1;
        tx_ready_b = 1'b1;
        mk(1, 1'b0, 32'h71, ADDR_A, 1'b1);
        mk(1, 1'b0, 32'h72, ADDR_A, 1'b0);
        mk(1, 1'b0, 32'h73, ADDR_A, 1'b0);
        mk(1, 1'b1, 32'h74, ADDR_A, 1'b0);
        model_run();
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            tick();
            if (outvalidA && !outsopA) found = 1'b1;
        end
        chk("rst_mid_reached", found, 1);
        tx_ready_a = 1'b0;
        tx_ready_b = 1'b0;
        rstn = 1'b0;
        tick();
        chk("midrst_valid", {outvalidA, outvalidB}, 0);
        chk("midrst_data", {outdataA, outdataB}, 0);
        chk("midrst_sopeop", {outsopA, outsopB, outeopA, outeopB}, 0);
        chk("midrst_rd_en", {fifo_rd_en_a, fifo_rd_en_b}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnts", {drop_cnt, err_cnt}, 0);
        qa.delete(); qb.delete(); expQ.delete();
        mErr = 0; mDrop = 0; mRr = 1'b0;
        fifo_empty_a = 1'b1; fifo_empty_b = 1'b1;
        fifo_dout_a = '0; fifo_dout_b = '0;
        tick();
        rstn = 1'b1;
        readyMode = 1;
        mk(1, 1'b0, 32'h81, ADDR_B, 1'b1);
        mk(1, 1'b1, 32'h82, ADDR_B, 1'b0);
        model_run();
        drain();
        mk(0, 1'b1, 32'h91, ADDR_A, 1'b1);
        mk(1, 1'b1, 32'hA1, ADDR_A, 1'b1);
        model_run();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
`default_nettype wire
